dp_mem_port: RTL

//  Parametrised MAR/MDR memory-port unit for the LC-3 datapath; supersedes the bare MAR/MDR regs + MIO_EN mux.

---
 rtl/dp_mem_port_if.sv | 45 ++++
 rtl/dp_mem_port.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/dp_mem_port_if.sv
// rtl/dp_mem_port_if.sv - Datapath/memory-side signal bundle for dp_mem_port
// Stats counters exist only when DP_MEM_STATS_EN is defined.
interface dp_mem_port_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic [DATA_W-1:0] BUS;
   logic              LD_MAR;
   logic              LD_MDR;
   logic              MIO_EN;
   logic              req_rd;
   logic              req_wr;
   logic [DATA_W-1:0] mem_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ce;
   logic              mem_we;
   logic [ADDR_W-1:0] MAR;
   logic [DATA_W-1:0] MDR;
   logic              R;
   logic              busy;
   logic              err;
`ifdef DP_MEM_STATS_EN
   logic [15:0]       rd_count;
   logic [15:0]       wr_count;

   modport master (
      output BUS, LD_MAR, LD_MDR, MIO_EN, req_rd, req_wr, mem_rdata,
      input  mem_addr, mem_wdata, mem_ce, mem_we, MAR, MDR, R, busy, err, rd_count, wr_count
   );
   modport slave (
      input  BUS, LD_MAR, LD_MDR, MIO_EN, req_rd, req_wr, mem_rdata,
      output mem_addr, mem_wdata, mem_ce, mem_we, MAR, MDR, R, busy, err, rd_count, wr_count
   );
`else
   modport master (
      output BUS, LD_MAR, LD_MDR, MIO_EN, req_rd, req_wr, mem_rdata,
      input  mem_addr, mem_wdata, mem_ce, mem_we, MAR, MDR, R, busy, err
   );
   modport slave (
      input  BUS, LD_MAR, LD_MDR, MIO_EN, req_rd, req_wr, mem_rdata,
      output mem_addr, mem_wdata, mem_ce, mem_we, MAR, MDR, R, busy, err
   );
`endif
endinterface

// File: rtl/dp_mem_port.sv
// rtl/dp_mem_port.sv - LC-3 MAR/MDR memory-port unit with wait-stated SRAM access FSM
// Optional completed-access counters under macro DP_MEM_STATS_EN.
module dp_mem_port #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 16,
   parameter int WAIT_CYC = 2
) (
   input logic          Clk,
   input logic          Reset_ah,
   dp_mem_port_if.slave port
);
   localparam int CNT_W = (WAIT_CYC < 1) ? 1 : $clog2(WAIT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_DONE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  count;
   logic              op_wr;
   logic [ADDR_W-1:0] mar_q;
   logic [DATA_W-1:0] mdr_q;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic              ce_q;
   logic              we_q;
   logic              busy_q;
   logic              r_q;
   logic              err_q;
   logic              any_strobe;

   assign any_strobe = port.req_rd | port.req_wr | port.LD_MAR | port.LD_MDR;

   // The access runs from a snapshot of MAR/MDR so a same-edge load only affects later accesses.
   assign port.mem_addr  = busy_q ? acc_addr  : mar_q;
   assign port.mem_wdata = busy_q ? acc_wdata : mdr_q;
   assign port.mem_ce    = ce_q;
   assign port.mem_we    = we_q;
   assign port.MAR       = mar_q;
   assign port.MDR       = mdr_q;
   assign port.R         = r_q;
   assign port.busy      = busy_q;
   assign port.err       = err_q;

`ifdef DP_MEM_STATS_EN
   logic [15:0] rd_cnt;
   logic [15:0] wr_cnt;

   assign port.rd_count = rd_cnt;
   assign port.wr_count = wr_cnt;
`endif

   always_ff @(posedge Clk) begin
      if (Reset_ah) begin
         state     <= ST_IDLE;
         count     <= '0;
         op_wr     <= 1'b0;
         mar_q     <= '0;
         mdr_q     <= '0;
         acc_addr  <= '0;
         acc_wdata <= '0;
         ce_q      <= 1'b0;
         we_q      <= 1'b0;
         busy_q    <= 1'b0;
         r_q       <= 1'b0;
         err_q     <= 1'b0;
`ifdef DP_MEM_STATS_EN
         rd_cnt    <= '0;
         wr_cnt    <= '0;
`endif
      end else begin
         r_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (port.LD_MAR) begin
                  mar_q <= port.BUS[ADDR_W-1:0];
               end
               if (port.LD_MDR) begin
                  mdr_q <= port.MIO_EN ? port.mem_rdata : port.BUS;
               end
               if (port.req_rd && port.req_wr) begin
                  err_q <= 1'b1;
               end else if (port.req_rd || port.req_wr) begin
                  state     <= ST_ACCESS;
                  op_wr     <= port.req_wr;
                  count     <= '0;
                  acc_addr  <= mar_q;
                  acc_wdata <= mdr_q;
                  ce_q      <= 1'b1;
                  we_q      <= port.req_wr;
                  busy_q    <= 1'b1;
               end
            end

            ST_ACCESS: begin
               if (any_strobe) begin
                  err_q <= 1'b1;
               end
               if (count == CNT_LAST) begin
                  state <= ST_DONE;
                  ce_q  <= 1'b0;
                  we_q  <= 1'b0;
                  r_q   <= 1'b1;
                  if (!op_wr) begin
                     mdr_q <= port.mem_rdata;
                  end
`ifdef DP_MEM_STATS_EN
                  if (op_wr) begin
                     if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
                  end else begin
                     if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
                  end
`endif
               end else begin
                  count <= count + CNT_ONE;
               end
            end

            ST_DONE: begin
               if (any_strobe) begin
                  err_q <= 1'b1;
               end
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end

            default: begin
               state  <= ST_IDLE;
               ce_q   <= 1'b0;
               we_q   <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end
endmodule
